// File: rtl/text_stream_loader.sv
// Streams text symbols from a valid/ready source into the BWT text memory, then appends the sentinel.
// Optional NEWLINE_FILTER_EN: accept 0x0A/0x0D but neither write nor count them.
module text_stream_loader #(
    parameter int             DW       = 8,
    parameter int             AW       = 10,
    parameter int             DEPTH    = 1024,
    parameter logic [DW-1:0]  SENTINEL = 8'h24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   length,
    output logic          overflow
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, TERM, DONE} state_t;

    // The last text slot; filling it without s_last means the text must be truncated.
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          accept;
    logic          skip;

    assign accept = s_valid & s_ready;

`ifdef NEWLINE_FILTER_EN
    assign skip = (s_data == DW'(8'h0A)) || (s_data == DW'(8'h0D));
`else
    assign skip = 1'b0;
`endif

    // s_ready is registered: raised on start, dropped once the final symbol is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            s_ready  <= 1'b0;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            length   <= '0;
            overflow <= 1'b0;
        end else begin
            mem_wen <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        length   <= '0;
                        busy     <= 1'b1;
                        s_ready  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (!skip) begin
                            mem_wen  <= 1'b1;
                            mem_addr <= cnt;
                            mem_din  <= s_data;
                            cnt      <= cnt + CNT_ONE;
                        end
                        if (s_last) begin
                            state   <= TERM;
                            s_ready <= 1'b0;
                        end else if (!skip && cnt == LAST_IDX) begin
                            overflow <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last) begin
                        state   <= TERM;
                        s_ready <= 1'b0;
                    end
                end
                TERM: begin
                    mem_wen  <= 1'b1;
                    mem_addr <= cnt;
                    mem_din  <= SENTINEL;
                    length   <= {1'b0, cnt} + LEN_ONE;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_stream_loader.sv
// Directed bench for text_stream_loader with an 8-word memory; expected writes are hand-written strings ending in '$'.
module tb_text_stream_loader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          done;
    logic [AW:0]   length;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int acc_cyc[$];
    int waited;
    int low_cnt;

    text_stream_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SENTINEL(8'h24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .busy(busy), .done(done), .length(length), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each write is held for exactly one cycle, so the falling edge sees it once.
    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_din));
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last, output int nwait);
        nwait   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (s_ready !== 1'b1 && nwait < 50) begin
            @(negedge clk);
            nwait++;
        end
        if (s_ready !== 1'b1) checkOutput("accept_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc.push_back(cyc);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic sendText(input string txt);
        int w;
        for (int i = 0; i < txt.len(); i++)
            applyStimulus(txt[i], i == txt.len() - 1, w);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    // Writes must land at consecutive addresses from 0 with the bytes of exp in order.
    task automatic checkWrites(input string tag, input string exp);
        checkOutput({tag, "_nwrites"}, 32'(wr_data.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            if (i < wr_data.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp[i]));
                checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            end else begin
                checkOutput($sformatf("%s_missing%0d", tag, i), 32'(wr_data.size()), 32'(exp.len()));
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outs", 32'({s_ready, mem_wen, mem_addr, mem_din, busy, done, length, overflow}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] banana");
        clearLog();
        pulseStart();
        checkOutput("banana_busy", 32'(busy), 32'd1);
        checkOutput("banana_ready", 32'(s_ready), 32'd1);
        sendText("banana");
        waitDone("banana");
        checkWrites("banana", "banana$");
        checkOutput("banana_len", 32'(length), 32'd7);
        checkOutput("banana_ovf", 32'(overflow), 32'd0);
        checkOutput("banana_busy_end", 32'(busy), 32'd0);
        checkOutput("banana_ready_end", 32'(s_ready), 32'd0);

        $display("[TB] overflow");
        clearLog();
        pulseStart();
        checkOutput("restart_done_clr", 32'(done), 32'd0);
        checkOutput("restart_len_clr", 32'(length), 32'd0);
        low_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'h41 + 8'(i), i == 11, waited);
            low_cnt += waited;
            if (i < 11 && s_ready !== 1'b1) low_cnt++;
        end
        checkOutput("ovf_ready_stalls", 32'(low_cnt), 32'd0);
        checkOutput("ovf_accepts", 32'(acc_cyc.size()), 32'd12);
        waitDone("ovf");
        checkWrites("ovf", "ABCDEFG$");
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_len", 32'(length), 32'd8);

        $display("[TB] abc with gaps and stray starts");
        clearLog();
        pulseStart();
        start = 1'b1;
        applyStimulus("a", 1'b0, waited);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        applyStimulus("b", 1'b0, waited);
        start = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        applyStimulus("c", 1'b1, waited);
        waitDone("abc");
        checkWrites("abc", "abc$");
        checkOutput("abc_len", 32'(length), 32'd4);
        for (int i = 0; i < 3; i++)
            if (i < wr_cyc.size() && i < acc_cyc.size())
                checkOutput($sformatf("abc_lat%0d", i), 32'(wr_cyc[i]), 32'(acc_cyc[i]));

        $display("[TB] reset mid-load");
        clearLog();
        pulseStart();
        applyStimulus("h", 1'b0, waited);
        applyStimulus("e", 1'b0, waited);
        applyStimulus("l", 1'b0, waited);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset_outs", 32'({s_ready, mem_wen, mem_addr, mem_din, busy, done, length, overflow}), 32'd0);
        clearLog();
        @(negedge clk);
        pulseStart();
        sendText("hi");
        waitDone("hi");
        checkWrites("hi", "hi$");
        checkOutput("hi_len", 32'(length), 32'd3);

        $display("[TB] newline filter");
        clearLog();
        pulseStart();
        sendText("ab\r\n");
        waitDone("crlf");
`ifdef NEWLINE_FILTER_EN
        checkWrites("crlf", "ab$");
        checkOutput("crlf_len", 32'(length), 32'd3);
`else
        checkWrites("crlf", "ab\r\n$");
        checkOutput("crlf_len", 32'(length), 32'd5);
`endif

        $display("[TB] single symbol and reload");
        clearLog();
        pulseStart();
        sendText("x");
        waitDone("x");
        checkWrites("x", "x$");
        checkOutput("x_len", 32'(length), 32'd2);
        checkOutput("x_ovf", 32'(overflow), 32'd0);
        clearLog();
        pulseStart();
        sendText("z");
        waitDone("z");
        checkWrites("z", "z$");
        checkOutput("z_len", 32'(length), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
